fir_sequencer: RTL and testbench
================================

Name: fir_sequencer

Overview:
- Controls one n_tap_fir instance: loads coefficients from a synchronous coefficient ROM, streams accepted samples into it, flushes the delay line, then ends the run.
- Drives every FIR control input (coefficientIn, coefficientsSetFlag, loadDataFlag, stopDataLoadFlag, dataIn).
- Sits between the sample source or ROM and the FIR filter; a top-level FSM sequences runs through start/done.

Parameters:
- LENGTH, 20, FIR tap count; must equal the FIR's LENGTH.
- DATA_WIDTH, 8, coefficient and sample width.
- ADDR_WIDTH, 5, coefficient ROM address width; must satisfy 2^ADDR_WIDTH >= LENGTH.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run, honoured only in IDLE.
- coeffAddr  out  ADDR_WIDTH  coefficient ROM read address.
- coeffData  in  DATA_WIDTH signed  ROM read data; valid 1 cycle after coeffAddr.
- sampleIn  in  DATA_WIDTH signed  input sample.
- sampleValid  in  1  sampleIn valid.
- sampleLast  in  1  marks the final sample; qualified by sampleValid && sampleReady.
- sampleReady  out  1  sequencer accepts a sample this cycle.
- coefficientOut  out  DATA_WIDTH signed  to FIR coefficientIn.
- coefficientsSetFlag  out  1  to FIR; high with the final coefficient.
- dataOut  out  DATA_WIDTH signed  to FIR dataIn.
- loadDataFlag  out  1  to FIR; dataOut is valid.
- stopDataLoadFlag  out  1  to FIR; one-cycle pulse that ends the run.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset values: state IDLE, all counters 0, coeffAddr 0. Every output is 0.
- IDLE:
  - sampleReady=0. coefficientOut, dataOut, loadDataFlag and all flags are 0.
  - start -> PREFETCH.
  - The FIR sits in LOAD_COEFFICIENTS shifting zeros; this is harmless.
- PREFETCH (1 cycle): coeffAddr=0, k=0 -> LOAD.
- LOAD (LENGTH cycles):
  - Each cycle: register coefficientOut<=coeffData (the value for address k), coeffAddr<=k+1, k<=k+1.
  - Coefficient k reaches the FIR in a single cycle, in address order 0..LENGTH-1, with no gaps.
  - coefficientsSetFlag is high only in the cycle coefficientOut carries address LENGTH-1.
  - That cycle -> RUN. coefficientOut returns to 0 one cycle later.
- RUN:
  - sampleReady=1.
  - On sampleValid: dataOut<=sampleIn and loadDataFlag<=1 on the next cycle (1-cycle latency).
  - Otherwise loadDataFlag<=0 and dataOut holds its value.
  - Samples accepted back-to-back, one per cycle.
  - Accepted sampleLast -> FLUSH when FIR_FLUSH_EN is defined, else -> STOP.
  - sampleLast without sampleValid is ignored.
- FLUSH (LENGTH-1 cycles): sampleReady=0; drives dataOut=0 with loadDataFlag=1 each cycle -> STOP.
- STOP (1 cycle): stopDataLoadFlag=1, loadDataFlag=0, sampleReady=0 -> DONE.
- DONE (2 cycles):
  - done=1 in the first cycle only.
  - The second cycle covers the FIR's 2-cycle STOP->IDLE->LOAD_COEFFICIENTS recovery.
  - -> IDLE.
- start outside IDLE is ignored. start asserted together with reset: reset wins.
- Reset mid-run: all outputs are 0 the next cycle and state is IDLE. The FIR has no reset; the next run's LOAD overwrites its coefficients.
- Unused state encodings -> IDLE with outputs cleared.
- coeffAddr never exceeds LENGTH-1; it holds that value once LOAD ends.
- The flush counter wraps at no point; it terminates exactly at LENGTH-1.

Optional Feature:
- FIR_FLUSH_EN defined: the FLUSH state exists; LENGTH-1 trailing zeros are pushed so the full convolution tail appears on the FIR output.
- Not defined: FLUSH is removed; the accepted sampleLast goes straight to STOP; output is truncated at the last sample.

Test Plan:
- Reset then start, LENGTH=4, ROM={1,2,3,4}:
  - coefficientOut=1,2,3,4 on consecutive cycles; coefficientsSetFlag high only with 4; state is RUN the next cycle.
- RUN, LENGTH=4, samples {5,-3,7} back-to-back, last on 7:
  - dataOut=5,-3,7 each 1 cycle after acceptance with loadDataFlag=1.
  - With FIR_FLUSH_EN: 3 zero pushes, then stopDataLoadFlag for 1 cycle, then done for 1 cycle.
  - Without FIR_FLUSH_EN: stopDataLoadFlag immediately after 7.
- sampleValid toggling 1,0,1: loadDataFlag=1,0,1 and dataOut holds across the gap.
- start pulsed during RUN: no effect. start during DONE: ignored. start in IDLE: a new run starts.
- Reset asserted mid-LOAD at k=2: next cycle busy=0, every output 0, coeffAddr=0. A subsequent start reloads all LENGTH coefficients.
- Integrated with n_tap_fir, LENGTH=4, coefficients {1,1,1,1}, samples {1,2,3,4}: FIR outputs follow the running sum 1,3,6,10. With FIR_FLUSH_EN, the tail is 9,7,4.

Source files
------------

// File: rtl/fir_sequencer.sv
// fir_sequencer: runs one n_tap_fir through coefficient load, sample streaming and stop.
// Define FIR_FLUSH_EN to push LENGTH-1 trailing zeros so the full convolution tail comes out.
module fir_sequencer #(
   parameter int LENGTH     = 20,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   output logic [ADDR_WIDTH-1:0]        coeffAddr,
   input  logic signed [DATA_WIDTH-1:0] coeffData,
   input  logic signed [DATA_WIDTH-1:0] sampleIn,
   input  logic                         sampleValid,
   input  logic                         sampleLast,
   output logic                         sampleReady,
   output logic signed [DATA_WIDTH-1:0] coefficientOut,
   output logic                         coefficientsSetFlag,
   output logic signed [DATA_WIDTH-1:0] dataOut,
   output logic                         loadDataFlag,
   output logic                         stopDataLoadFlag,
   output logic                         busy,
   output logic                         done
);

   // state    | meaning
   // IDLE     | waiting for start, FIR outputs held low
   // PREFETCH | ROM address 0 in flight
   // LOAD     | forwarding coefficient k, one per cycle
   // RUN      | accepting samples
   // FLUSH    | pushing LENGTH-1 zero samples (FIR_FLUSH_EN only)
   // STOP     | ending the FIR data load
   // DONE     | done pulse, then FIR STOP->IDLE recovery
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREFETCH = 3'd1,
      LOAD     = 3'd2,
      RUN      = 3'd3,
      FLUSH    = 3'd4,
      STOP     = 3'd5,
      DONE     = 3'd6
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LENGTH - 1);
   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = (LENGTH > 1) ? ADDR_WIDTH'(1) : '0;
`ifdef FIR_FLUSH_EN
   localparam logic [ADDR_WIDTH-1:0] FLUSH_LAST = ADDR_WIDTH'((LENGTH > 1) ? LENGTH - 2 : 0);
`endif

   state_t                         state_q, nxt_state;
   logic [ADDR_WIDTH-1:0]          k_q, nxt_k;
   logic [ADDR_WIDTH-1:0]          cnt_q, nxt_cnt;
   logic [ADDR_WIDTH-1:0]          nxt_addr;
   logic [ADDR_WIDTH:0]            k_plus2;
   logic signed [DATA_WIDTH-1:0]   nxt_coef, nxt_data;
   logic                           nxt_cset, nxt_load, nxt_stop, nxt_done;

   assign busy        = (state_q != IDLE);
   assign sampleReady = (state_q == RUN);

   // FIR-facing outputs are registered, so each state's action reaches the pins one cycle later.
   always_comb begin
      nxt_state = state_q;
      nxt_k     = k_q;
      nxt_cnt   = cnt_q;
      nxt_addr  = coeffAddr;
      nxt_coef  = '0;
      nxt_cset  = 1'b0;
      nxt_data  = '0;
      nxt_load  = 1'b0;
      nxt_stop  = 1'b0;
      nxt_done  = 1'b0;
      k_plus2   = {1'b0, k_q} + (ADDR_WIDTH + 1)'(2);
      case (state_q)
         IDLE: begin
            if (start) begin
               nxt_state = PREFETCH;
               nxt_addr  = '0;
               nxt_k     = '0;
            end
         end
         PREFETCH: begin
            nxt_state = LOAD;
            nxt_addr  = FIRST_ADDR;
            nxt_k     = '0;
         end
         LOAD: begin
            // address runs one ahead of k to hide the ROM read latency
            nxt_coef = coeffData;
            nxt_k    = k_q + ADDR_WIDTH'(1);
            nxt_addr = (k_plus2 > {1'b0, LAST_ADDR}) ? LAST_ADDR : k_plus2[ADDR_WIDTH-1:0];
            if (k_q == LAST_ADDR) begin
               nxt_cset  = 1'b1;
               nxt_k     = '0;
               nxt_state = RUN;
            end
         end
         RUN: begin
            nxt_data = dataOut;
            if (sampleValid) begin
               nxt_data = sampleIn;
               nxt_load = 1'b1;
               if (sampleLast) begin
`ifdef FIR_FLUSH_EN
                  if (LENGTH > 1) begin
                     nxt_state = FLUSH;
                     nxt_cnt   = FLUSH_LAST;
                  end else begin
                     nxt_state = STOP;
                  end
`else
                  nxt_state = STOP;
`endif
               end
            end
         end
`ifdef FIR_FLUSH_EN
         FLUSH: begin
            nxt_load = 1'b1;
            if (cnt_q == '0) nxt_state = STOP;
            else             nxt_cnt   = cnt_q - ADDR_WIDTH'(1);
         end
`endif
         STOP: begin
            nxt_stop  = 1'b1;
            nxt_cnt   = ADDR_WIDTH'(1);
            nxt_state = DONE;
         end
         DONE: begin
            if (cnt_q != '0) begin
               nxt_done = 1'b1;
               nxt_cnt  = '0;
            end else begin
               nxt_state = IDLE;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_addr  = '0;
            nxt_k     = '0;
            nxt_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q             <= IDLE;
         k_q                 <= '0;
         cnt_q               <= '0;
         coeffAddr           <= '0;
         coefficientOut      <= '0;
         coefficientsSetFlag <= 1'b0;
         dataOut             <= '0;
         loadDataFlag        <= 1'b0;
         stopDataLoadFlag    <= 1'b0;
         done                <= 1'b0;
      end else begin
         state_q             <= nxt_state;
         k_q                 <= nxt_k;
         cnt_q               <= nxt_cnt;
         coeffAddr           <= nxt_addr;
         coefficientOut      <= nxt_coef;
         coefficientsSetFlag <= nxt_cset;
         dataOut             <= nxt_data;
         loadDataFlag        <= nxt_load;
         stopDataLoadFlag    <= nxt_stop;
         done                <= nxt_done;
      end
   end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: random runs of fir_sequencer against a ROM model and an event scoreboard.
// Expected FIR-side events are queued as stimulus is issued; a negedge monitor pops and compares.
module tb_fir_sequencer;
   localparam int L  = 4;
   localparam int DW = 8;
   localparam int AW = 2;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [AW-1:0]        coeffAddr;
   logic signed [DW-1:0] coeffData = '0;
   logic signed [DW-1:0] sampleIn = '0;
   logic                 sampleValid = 1'b0;
   logic                 sampleLast = 1'b0;
   logic                 sampleReady;
   logic signed [DW-1:0] coefficientOut;
   logic                 coefficientsSetFlag;
   logic signed [DW-1:0] dataOut;
   logic                 loadDataFlag;
   logic                 stopDataLoadFlag;
   logic                 busy;
   logic                 done;

   fir_sequencer #(.LENGTH(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .start(start),
      .coeffAddr(coeffAddr), .coeffData(coeffData),
      .sampleIn(sampleIn), .sampleValid(sampleValid), .sampleLast(sampleLast),
      .sampleReady(sampleReady),
      .coefficientOut(coefficientOut), .coefficientsSetFlag(coefficientsSetFlag),
      .dataOut(dataOut), .loadDataFlag(loadDataFlag), .stopDataLoadFlag(stopDataLoadFlag),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic signed [DW-1:0] rom_mem [L];
   always @(posedge clock) coeffData <= rom_mem[coeffAddr];

   typedef enum {EV_COEF, EV_DATA, EV_STOP, EV_DONE} ev_kind_t;
   typedef struct {ev_kind_t kind; int value;} ev_t;
   ev_t exp_q[$];

   int total = 0;
   int bad   = 0;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push_ev(input ev_kind_t kind, input int value);
      ev_t e;
      e.kind  = kind;
      e.value = value;
      exp_q.push_back(e);
   endfunction

   function automatic void pop_expect(input ev_kind_t kind, input int act, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got unexpected event value %0d, expected no event", name, act);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind) begin
            total++;
            bad++;
            $display("FAIL %s: got event kind %0d, expected kind %0d", name, int'(kind), int'(e.kind));
         end else begin
            chk(name, act, e.value);
         end
      end
   endfunction

   // monitor
   bit collecting = 1'b0;
   bit busy_prev  = 1'b0;
   bit ready_prev = 1'b0;
   int win[$];
   int last_data  = 0;
   int idle_bits;

   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         win.delete();
         collecting = 1'b0;
         busy_prev  = 1'b0;
         ready_prev = 1'b0;
         last_data  = 0;
      end else begin
         if (busy && !busy_prev) begin
            win.delete();
            collecting = 1'b1;
            last_data  = 0;
         end
         if (collecting) begin
            win.push_back(int'(coefficientOut));
            if (coefficientsSetFlag) begin
               if (win.size() < L) begin
                  chk("coef_count", win.size(), L);
               end else begin
                  for (int i = 0; i < win.size() - L; i++) chk("coef_lead_zero", win[i], 0);
                  for (int j = 0; j < L; j++) pop_expect(EV_COEF, win[win.size() - L + j], "coef");
               end
               collecting = 1'b0;
            end else if (win.size() > L + 8) begin
               chk("coef_set_timeout", 0, 1);
               collecting = 1'b0;
            end
         end else begin
            chk("coef_out_outside_load", int'(coefficientOut), 0);
            chk("coef_set_outside_load", int'(coefficientsSetFlag), 0);
         end
         if (loadDataFlag) begin
            pop_expect(EV_DATA, int'(dataOut), "data");
            last_data = int'(dataOut);
         end else if (ready_prev) begin
            chk("data_hold", int'(dataOut), last_data);
         end
         if (stopDataLoadFlag) begin
            pop_expect(EV_STOP, 0, "stop");
            chk("stop_load_low", int'(loadDataFlag), 0);
         end
         if (done) pop_expect(EV_DONE, 0, "done");
         if (!busy) begin
            idle_bits = {10'd0, coefficientOut, coefficientsSetFlag, dataOut,
                         loadDataFlag, stopDataLoadFlag, sampleReady, done};
            chk("idle_outputs", idle_bits, 0);
         end
         busy_prev  = busy;
         ready_prev = sampleReady;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int cyc = 0;
      while (busy && cyc < 80) begin
         tick();
         cyc++;
      end
      if (busy) chk(name, 0, 1);
   endtask

   task automatic do_run(input int smp[$], input bit vld[$], input int poke_at, input bit poke_done);
      int si  = 0;
      int cyc = 0;
      start = 1'b1;
      for (int k = 0; k < L; k++) push_ev(EV_COEF, int'(rom_mem[k]));
      tick();
      start = 1'b0;
      while (!sampleReady && cyc < 40) begin
         tick();
         cyc++;
      end
      if (!sampleReady) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      for (int i = 0; i < vld.size(); i++) begin
         sampleValid = vld[i];
         if (vld[i]) begin
            sampleIn   = DW'(smp[si]);
            sampleLast = (si == smp.size() - 1);
            push_ev(EV_DATA, smp[si]);
            si++;
         end else begin
            sampleIn   = DW'($urandom);
            sampleLast = 1'($urandom_range(1));
         end
         start = (i == poke_at);
         tick();
         start = 1'b0;
      end
      sampleValid = 1'b0;
      sampleLast  = 1'b0;
`ifdef FIR_FLUSH_EN
      for (int z = 0; z < L - 1; z++) push_ev(EV_DATA, 0);
`endif
      push_ev(EV_STOP, 0);
      push_ev(EV_DONE, 0);
      if (poke_done) begin
         cyc = 0;
         while (!done && cyc < 60) begin
            tick();
            cyc++;
         end
         if (!done) begin
            chk("done_timeout", 0, 1);
         end else begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("busy_after_start_in_done", int'(busy), 0);
            tick();
            chk("busy_stays_idle", int'(busy), 0);
         end
      end
      wait_idle("run_end_timeout");
   endtask

   task automatic random_run(input int poke_at, input bit poke_done);
      int smp[$];
      bit vld[$];
      logic signed [DW-1:0] r;
      int n = $urandom_range(1, 6);
      for (int k = 0; k < L; k++) rom_mem[k] = DW'($urandom);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(2) == 0) vld.push_back(1'b0);
         vld.push_back(1'b1);
         r = DW'($urandom);
         smp.push_back(int'(r));
      end
      do_run(smp, vld, poke_at, poke_done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int smp[$];
      bit vld[$];
      for (int k = 0; k < L; k++) rom_mem[k] = '0;
      repeat (3) tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_coeffAddr", int'(coeffAddr), 0);
      chk("rst_dataOut", int'(dataOut), 0);
      chk("rst_ready", int'(sampleReady), 0);
      reset = 1'b0;
      tick();

      // directed: ROM {1,2,3,4}, samples 5,-3,7 back-to-back
      for (int k = 0; k < L; k++) rom_mem[k] = DW'(k + 1);
      smp.push_back(5);  smp.push_back(-3); smp.push_back(7);
      vld.push_back(1'b1); vld.push_back(1'b1); vld.push_back(1'b1);
      do_run(smp, vld, -1, 1'b0);

      // sampleValid 1,0,1 with a start pulse in the gap
      smp.delete();
      vld.delete();
      for (int k = 0; k < L; k++) rom_mem[k] = DW'($urandom);
      smp.push_back(-100); smp.push_back(42);
      vld.push_back(1'b1); vld.push_back(1'b0); vld.push_back(1'b1);
      do_run(smp, vld, 1, 1'b0);

      // start while DONE is ignored
      random_run(-1, 1'b1);

      // reset in LOAD at k=2, start held with it
      for (int k = 0; k < L; k++) rom_mem[k] = DW'($urandom_range(1, 100));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_in_prefetch", int'(busy), 1);
      repeat (3) tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_coeffAddr", int'(coeffAddr), 0);
      chk("midrst_coefOut", int'(coefficientOut), 0);
      chk("midrst_coefSet", int'(coefficientsSetFlag), 0);
      chk("midrst_load", int'(loadDataFlag), 0);
      chk("midrst_done", int'(done), 0);
      reset = 1'b0;
      start = 1'b0;
      tick();
      tick();
      chk("idle_after_midrst", int'(busy), 0);
      random_run(-1, 1'b0);

      for (int r = 0; r < 10; r++) random_run(int'($urandom_range(0, 4)) - 1, 1'b0);

      repeat (5) tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
